rv_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the next-generation RV32 core. Replaces the single-cycle opcode decoder.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, with variable-latency ready handshakes on instruction and data memory.
- Drives PC, IR, register-file, ALU-mux, memory and writeback-mux enables.
- Flags illegal opcodes and memory timeouts by halting.

---
 rtl/rv_mc_pkg.sv | 27 ++
 rtl/rv_mc_wait_timer.sv | 17 +
 rtl/rv_multicycle_ctrl.sv | 98 +++++++++
 tb/tb_rv_multicycle_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_mc_pkg.sv
// rv_mc_pkg: opcodes, state and mux encodings, and the legal-opcode check for rv_multicycle_ctrl
package rv_mc_pkg;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } state_t;
   localparam logic [1:0] PC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_IMM   = 2'd1;
   localparam logic [1:0] PC_RS1   = 2'd2;
   localparam logic [1:0] WB_ALU   = 2'd0;
   localparam logic [1:0] WB_MEM   = 2'd1;
   localparam logic [1:0] WB_PC4   = 2'd2;
   function automatic logic is_legal(input logic [6:0] op);
      return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
   endfunction
endpackage

// File: rtl/rv_mc_wait_timer.sv
// rv_mc_wait_timer: counts cycles a request is held without ready; timeout when the count reaches WAIT_LIMIT
// Ports: clk, reset (async, active-high), hold (request pending, ready low), timeout.
module rv_mc_wait_timer #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic hold,
   output logic timeout
);
   logic [7:0] cnt;
   assign timeout = hold && cnt == 8'(WAIT_LIMIT);
   // a ready, a dropped request or the timeout itself each leave the state, so all clear the count
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else       cnt <= (hold && !timeout) ? cnt + 8'd1 : '0;
endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle RV32 control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with memory ready handshakes
// Ports: clk, reset (async, active-high), opcode, zero_flag, imem_ready, dmem_ready in;
//        imem_req, dmem_req, ir_write, pc_write, pc_sel, alu_src, mem_read, mem_write,
//        reg_write, mem_to_reg, halted, illegal_insn, bus_error, state out.
// Macro RV_MC_PERF_CNT_EN adds the retired and stall_cycles performance counters.
module rv_multicycle_ctrl
   import rv_mc_pkg::*;
#(
   parameter int WAIT_LIMIT = 15
`ifdef RV_MC_PERF_CNT_EN
   , parameter int CNT_WIDTH = 32
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       zero_flag,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_sel,
   output logic       alu_src,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] mem_to_reg,
   output logic       halted,
   output logic       illegal_insn,
   output logic       bus_error,
`ifdef RV_MC_PERF_CNT_EN
   output logic [CNT_WIDTH-1:0] retired,
   output logic [CNT_WIDTH-1:0] stall_cycles,
`endif
   output logic [2:0] state
);
   state_t     st, nx;
   logic [6:0] opq;
   logic       hold, timeout;
   assign state = st;
   // only the ready that matches the current request state counts
   assign hold = (st == S_FETCH && !imem_ready) || (st == S_MEM && !dmem_ready);
   rv_mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
      .clk(clk), .reset(reset), .hold(hold), .timeout(timeout)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) st <= S_FETCH;
      else       st <= nx;
   always_comb begin
      nx = st;
      case (st)
         S_FETCH:  nx = timeout ? S_HALT : imem_ready ? S_DECODE : S_FETCH;
         S_DECODE: nx = is_legal(opcode) ? S_EXEC : S_HALT;
         S_EXEC:   nx = opq == OP_BRANCH ? S_FETCH : (opq == OP_LOAD || opq == OP_STORE) ? S_MEM : S_WB;
         S_MEM:    nx = timeout ? S_HALT : !dmem_ready ? S_MEM : opq == OP_LOAD ? S_WB : S_FETCH;
         S_WB:     nx = S_FETCH;
         default:  nx = S_HALT;
      endcase
   end
   always_comb begin
      imem_req   = st == S_FETCH;
      ir_write   = imem_req && imem_ready;
      dmem_req   = st == S_MEM;
      mem_read   = dmem_req && opq == OP_LOAD;
      mem_write  = dmem_req && opq == OP_STORE;
      alu_src    = st == S_EXEC && opq != OP_R && opq != OP_BRANCH;
      reg_write  = st == S_WB;
      pc_write   = reg_write || (st == S_EXEC && opq == OP_BRANCH) || (mem_write && dmem_ready);
      pc_sel     = ((st == S_EXEC && opq == OP_BRANCH && zero_flag) || (reg_write && opq == OP_JAL)) ? PC_IMM :
                   (reg_write && opq == OP_JALR) ? PC_RS1 : PC_PLUS4;
      mem_to_reg = !reg_write ? WB_ALU : opq == OP_LOAD ? WB_MEM :
                   (opq == OP_JAL || opq == OP_JALR) ? WB_PC4 : WB_ALU;
      halted     = st == S_HALT;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         opq          <= '0;
         illegal_insn <= 1'b0;
         bus_error    <= 1'b0;
      end else begin
         if (st == S_DECODE) opq <= opcode;
         if (st == S_DECODE && !is_legal(opcode)) illegal_insn <= 1'b1;
         if (timeout) bus_error <= 1'b1;
      end
`ifdef RV_MC_PERF_CNT_EN
   // hold is exactly "request high with its ready low", which is the stall definition
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         retired      <= '0;
         stall_cycles <= '0;
      end else if (st != S_HALT) begin
         retired      <= retired + CNT_WIDTH'(pc_write);
         stall_cycles <= stall_cycles + CNT_WIDTH'(hold);
      end
`endif
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: table-driven scoreboard bench for rv_multicycle_ctrl
module tb_rv_multicycle_ctrl;
   import rv_mc_pkg::*;
   logic       clk = 0, reset = 1;
   logic [6:0] opcode = '0;
   logic       zero_flag = 0, imem_ready = 0, dmem_ready = 0;
   logic       imem_req, dmem_req, ir_write, pc_write, alu_src, mem_read, mem_write, reg_write;
   logic       halted, illegal_insn, bus_error;
   logic [1:0] pc_sel, mem_to_reg;
   logic [2:0] state;
`ifdef RV_MC_PERF_CNT_EN
   logic [31:0] retired, stall_cycles;
`endif
   always #5 clk = ~clk;
   rv_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero_flag(zero_flag),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write), .pc_write(pc_write),
      .pc_sel(pc_sel), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted),
      .illegal_insn(illegal_insn), .bus_error(bus_error),
`ifdef RV_MC_PERF_CNT_EN
      .retired(retired), .stall_cycles(stall_cycles),
`endif
      .state(state)
   );
   typedef struct {
      logic [6:0] op; logic z; int iw; int dw;
      int lat; int pcs; int m2r; int nrw; int nmr; int nmw; int nalu; int stall;
   } vec_t;
   vec_t tbl[$];
   vec_t exp_q[$];
   vec_t e;
   int nvec = 0, nfail = 0, ndone = 0;
   int cyc = 0, nir = 0, nrw = 0, nmr = 0, nmw = 0, nalu = 0, m2r = 0;
   logic [31:0] st0 = '0;
   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (reset) begin
         cyc = 0; nir = 0; nrw = 0; nmr = 0; nmw = 0; nalu = 0; m2r = 0;
      end else if (!halted) begin
`ifdef RV_MC_PERF_CNT_EN
         if (cyc == 0) st0 = stall_cycles;
`endif
         cyc++;
         nir += int'(ir_write);
         nrw += int'(reg_write);
         nmr += int'(mem_read);
         nmw += int'(mem_write);
         nalu += int'(alu_src);
         if (reg_write) m2r = int'(mem_to_reg);
         if (pc_write) begin
            if (exp_q.size() == 0) chk("spurious_pc_write", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk($sformatf("latency op=%b", e.op), cyc, e.lat);
               chk($sformatf("pc_sel op=%b", e.op), int'(pc_sel), e.pcs);
               chk($sformatf("mem_to_reg op=%b", e.op), m2r, e.m2r);
               chk($sformatf("ir_write op=%b", e.op), nir, 1);
               chk($sformatf("reg_write op=%b", e.op), nrw, e.nrw);
               chk($sformatf("mem_read op=%b", e.op), nmr, e.nmr);
               chk($sformatf("mem_write op=%b", e.op), nmw, e.nmw);
               chk($sformatf("alu_src op=%b", e.op), nalu, e.nalu);
`ifdef RV_MC_PERF_CNT_EN
               chk($sformatf("stall_cycles op=%b", e.op), int'(stall_cycles - st0), e.stall);
`endif
            end
            cyc = 0; nir = 0; nrw = 0; nmr = 0; nmw = 0; nalu = 0; m2r = 0;
            ndone++;
         end
      end
   end
   task automatic run_insn(input vec_t v);
      int ic = 0, mc = 0, d0 = ndone, n = 0;
      opcode = v.op;
      zero_flag = v.z;
      exp_q.push_back(v);
      while (ndone == d0 && n < 60) begin
         imem_ready = imem_req && ic == v.iw;
         ic = imem_req ? ic + 1 : 0;
         dmem_ready = dmem_req && mc == v.dw;
         mc = dmem_req ? mc + 1 : 0;
         @(posedge clk);
         #1;
         n++;
      end
      if (ndone == d0) begin
         chk($sformatf("completion op=%b", v.op), 0, 1);
         exp_q.delete();
      end
      imem_ready = 0;
      dmem_ready = 0;
   endtask
   function automatic vec_t mk(input logic [6:0] op, input logic z, input int iw, input int dw,
                               input int lat, input int pcs, input int m2r_e, input int nrw_e,
                               input int nmr_e, input int nmw_e, input int nalu_e, input int stall_e);
      vec_t v;
      v.op = op; v.z = z; v.iw = iw; v.dw = dw; v.lat = lat; v.pcs = pcs; v.m2r = m2r_e;
      v.nrw = nrw_e; v.nmr = nmr_e; v.nmw = nmw_e; v.nalu = nalu_e; v.stall = stall_e;
      return v;
   endfunction
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      //               op         z  iw  dw  lat pcs m2r rw  mr  mw  alu stall
      tbl.push_back(mk(OP_R,      0,  0,  0,  4,  0,  0,  1,  0,  0,  0,  0));
      tbl.push_back(mk(OP_IMM,    0,  0,  0,  4,  0,  0,  1,  0,  0,  1,  0));
      tbl.push_back(mk(OP_LOAD,   0,  0,  3,  8,  0,  1,  1,  4,  0,  1,  3));
      tbl.push_back(mk(OP_STORE,  0,  0,  0,  4,  0,  0,  0,  0,  1,  1,  0));
      tbl.push_back(mk(OP_BRANCH, 1,  0,  0,  3,  1,  0,  0,  0,  0,  0,  0));
      tbl.push_back(mk(OP_BRANCH, 0,  0,  0,  3,  0,  0,  0,  0,  0,  0,  0));
      tbl.push_back(mk(OP_JAL,    0,  0,  0,  4,  1,  2,  1,  0,  0,  1,  0));
      tbl.push_back(mk(OP_JALR,   1,  0,  0,  4,  2,  2,  1,  0,  0,  1,  0));
      tbl.push_back(mk(OP_R,      1,  2,  0,  6,  0,  0,  1,  0,  0,  0,  2));
      tbl.push_back(mk(OP_STORE,  0,  0,  2,  6,  0,  0,  0,  0,  3,  1,  2));
      tbl.push_back(mk(OP_LOAD,   0,  1,  0,  6,  0,  1,  1,  1,  0,  1,  1));
      tbl.push_back(mk(OP_LOAD,   0,  0, 15, 20,  0,  1,  1, 16,  0,  1, 15));
      tbl.push_back(mk(OP_R,      0, 15,  0, 19,  0,  0,  1,  0,  0,  0, 15));
      #2;
      chk("reset state", int'(state), 0);
      chk("reset halted", int'(halted), 0);
      chk("reset flags", int'({illegal_insn, bus_error}), 0);
      chk("reset enables", int'({pc_write, reg_write, ir_write, dmem_req, mem_read, mem_write}), 0);
      @(posedge clk);
      #1 reset = 0;
      foreach (tbl[i]) run_insn(tbl[i]);
      chk("back in fetch", int'(state), 0);
`ifdef RV_MC_PERF_CNT_EN
      chk("retired total", int'(retired), tbl.size());
`endif
      // illegal opcode halts after DECODE; readies are ignored while halted
      reset = 1;
      @(posedge clk);
      #1 reset = 0;
      opcode = 7'b1111111;
      imem_ready = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("illegal state", int'(state), 7);
      chk("illegal halted", int'(halted), 1);
      chk("illegal flag", int'(illegal_insn), 1);
      chk("illegal bus_error", int'(bus_error), 0);
      dmem_ready = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("halt enables", int'({imem_req, dmem_req, ir_write, pc_write, reg_write, mem_read, mem_write, alu_src}), 0);
         chk("halt absorbing", int'(state), 7);
      end
      #2 reset = 1;
      #1;
      chk("async reset state", int'(state), 0);
      chk("async reset flags", int'({halted, illegal_insn, bus_error}), 0);
      // fetch timeout: the 16th FETCH cycle without ready halts
      imem_ready = 0;
      dmem_ready = 0;
      opcode = OP_R;
      @(posedge clk);
      #1 reset = 0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("fetch 16th cycle state", int'(state), 0);
      chk("fetch 16th cycle bus_error", int'(bus_error), 0);
      @(posedge clk);
      @(negedge clk);
      chk("fetch timeout state", int'(state), 7);
      chk("fetch timeout bus_error", int'(bus_error), 1);
      chk("fetch timeout illegal", int'(illegal_insn), 0);
      #3 reset = 1;
      #1;
      chk("timeout reset state", int'(state), 0);
      chk("timeout reset flags", int'({halted, bus_error}), 0);
      // data timeout: 16 MEM cycles without dmem_ready
      opcode = OP_LOAD;
      imem_ready = 1;
      @(posedge clk);
      #1 reset = 0;
      @(posedge clk);
      #1 imem_ready = 0;
      repeat (17) @(posedge clk);
      @(negedge clk);
      chk("mem 16th cycle state", int'(state), 3);
      chk("mem 16th cycle mem_read", int'(mem_read), 1);
      @(posedge clk);
      @(negedge clk);
      chk("mem timeout state", int'(state), 7);
      chk("mem timeout bus_error", int'(bus_error), 1);
      #3 reset = 1;
      #1;
      chk("final reset flags", int'({halted, bus_error, illegal_insn}), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
